sphere_seq_requester: RTL

Initiator-side sequencer for the sphere point generator's start/ready/done handshake. Accepts a batch command (first index, point count, base selects) and issues one `gen_start` per index to the generator. Captures each `result_x/y/z` triple on `gen_done` and streams it out through a small FIFO with valid/ready backpressure. Sits between the host/DMA command path and the generator core, so the generator never needs software pacing.

---
 rtl/sphere_seq_pkg.sv | 26 ++
 rtl/sphere_seq_fifo.sv | 70 +++++++
 rtl/sphere_seq_requester.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/sphere_seq_pkg.sv
// Shared types and constants for the sphere point request sequencer.
package sphere_seq_pkg;

  // Sequencer control states.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_DRAIN     = 2'd3
  } state_e;

  // 1.0 in the generator's signed Q16.16 format.
  localparam logic [31:0] Q16_ONE = 32'h0001_0000;

  // One buffered result: index, three coordinates and the end-of-batch flag.
  localparam int unsigned ENTRY_W = 32 * 4 + 1;

  typedef struct packed {
    logic [31:0] k;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
    logic        last;
  } entry_t;

endpackage

// File: rtl/sphere_seq_fifo.sv
// Small synchronous FIFO with occupancy output; head is zero while empty.
module sphere_seq_fifo #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CW-1:0]    count_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

  // Pointer and occupancy next-state; flush wins over everything.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage: one write-enabled register row per entry.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_row
    always_ff @(posedge clk) begin
      if (do_push && !flush_i && (wr_ptr_q == AW'(gi))) mem_q[gi] <= data_i;
    end
  end

  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/sphere_seq_requester.sv
// Batch sequencer: issues one generator request per index and buffers results.
module sphere_seq_requester
  import sphere_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_k_start,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [1:0]       cmd_base_sel0,
  input  logic [1:0]       cmd_base_sel1,
  input  logic             abort,
  output logic             gen_start,
  output logic [31:0]      gen_k,
  output logic [1:0]       gen_base_sel0,
  output logic [1:0]       gen_base_sel1,
  input  logic             gen_ready,
  input  logic             gen_done,
  input  logic [31:0]      gen_x,
  input  logic [31:0]      gen_y,
  input  logic [31:0]      gen_z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_k,
  output logic [31:0]      out_x,
  output logic [31:0]      out_y,
  output logic [31:0]      out_z,
  output logic             out_last,
  output logic             busy
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  state_e             state_q;
  logic [31:0]        k_q;
  logic [CNT_W-1:0]   remaining_q;
  logic [1:0]         sel0_q;
  logic [1:0]         sel1_q;
  logic               discard_q;

  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_flush;
  logic               fifo_empty;
  logic [CW-1:0]      fifo_count;
  entry_t             push_entry;
  entry_t             head_entry;
  logic [ENTRY_W-1:0] head_bits;

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = !cmd_ready;

  // A request needs an idle generator and a free FIFO slot; the slot stays
  // reserved because nothing else pushes until this request's done arrives.
  assign gen_start = (state_q == ST_ISSUE) && gen_ready &&
                     (fifo_count < CW'(DEPTH)) && !abort;

  assign gen_k         = k_q;
  assign gen_base_sel0 = sel0_q;
  assign gen_base_sel1 = sel1_q;

  assign fifo_flush = abort && (state_q != ST_IDLE);
  assign fifo_push  = (state_q == ST_WAIT_DONE) && gen_done && !discard_q && !abort;
  assign fifo_pop   = out_valid && out_ready;

  assign push_entry = '{k: k_q, x: gen_x, y: gen_y, z: gen_z,
                        last: (remaining_q == CNT_W'(1))};

  sphere_seq_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (fifo_flush),
    .push_i  (fifo_push),
    .data_i  (push_entry),
    .pop_i   (fifo_pop),
    .head_o  (head_bits),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  assign head_entry = entry_t'(head_bits);
  assign out_valid  = !fifo_empty;
  assign out_k      = head_entry.k;
  assign out_x      = head_entry.x;
  assign out_y      = head_entry.y;
  assign out_z      = head_entry.z;
  assign out_last   = head_entry.last;

  // Batch control FSM; an abort during a request arms discard so the
  // uncancellable in-flight result is swallowed before returning to idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      remaining_q <= '0;
      sel0_q      <= '0;
      sel1_q      <= '0;
      discard_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            k_q         <= cmd_k_start;
            remaining_q <= cmd_count;
            sel0_q      <= cmd_base_sel0;
            sel1_q      <= cmd_base_sel1;
            if (cmd_count != '0) state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (abort)          state_q <= ST_IDLE;
          else if (gen_start) state_q <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (abort) discard_q <= 1'b1;
          if (gen_done) begin
            if (discard_q || abort) begin
              discard_q <= 1'b0;
              state_q   <= ST_IDLE;
            end else begin
              k_q         <= k_q + 32'd1;
              remaining_q <= remaining_q - CNT_W'(1);
              state_q     <= (remaining_q == CNT_W'(1)) ? ST_DRAIN : ST_ISSUE;
            end
          end
        end
        ST_DRAIN: begin
          if (abort || fifo_empty) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
